// File: rtl/ddr_arbiter.sv
// Two-client DDR command arbiter with in-order read-return routing via a tag FIFO.
// Define DDR_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (port 0 wins).
module ddr_arbiter #(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         c0_req,
    input  logic         c0_we,
    input  logic [27:0]  c0_addr,
    input  logic [127:0] c0_wdata,
    input  logic [15:0]  c0_wmask,
    output logic         c0_gnt,
    output logic         c0_rvalid,
    output logic [127:0] c0_rdata,

    input  logic         c1_req,
    input  logic         c1_we,
    input  logic [27:0]  c1_addr,
    input  logic [127:0] c1_wdata,
    input  logic [15:0]  c1_wmask,
    output logic         c1_gnt,
    output logic         c1_rvalid,
    output logic [127:0] c1_rdata,

    output logic [2:0]   ddr_cmd,
    output logic         ddr_cmd_en,
    output logic [27:0]  ddr_addr,
    output logic [127:0] ddr_wr_data,
    output logic [15:0]  ddr_wr_data_mask,
    output logic         ddr_wr_data_en,
    input  logic         ddr_calib_done,
    input  logic         ddr_cmd_ready,
    input  logic [127:0] ddr_rd_data,
    input  logic         ddr_rd_data_valid,

    output logic         busy,
    output logic         err
);

    localparam int unsigned CntW = $clog2(MAX_OUT + 1);
    localparam int unsigned PtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUT);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUT - 1);

    typedef enum logic {StWaitCal, StRun} state_e;

    state_e state_q, state_d;
    logic   run;

    logic                elig0, elig1, slot_free;
    logic                sel, sel_we, cmd_fire;
    logic                push, pop, spurious, head;

    logic [MAX_OUT-1:0]  tag_q, tag_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic [127:0]        rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                err_q, err_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // ---------------- FSM: state register / next state / outputs ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StWaitCal;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitCal: if (ddr_calib_done) state_d = StRun;
            StRun:     state_d = StRun;
            default:   state_d = StWaitCal;
        endcase
    end

    // Gated by rst_n so nothing is issued while reset is held, even before the first edge.
    always_comb begin
        run = (state_q == StRun) && rst_n;
    end

    // ---------------- Arbitration ----------------
    always_comb begin
        slot_free = (cnt_q < MaxCnt);
        elig0     = run && c0_req && (c0_we || slot_free);
        elig1     = run && c1_req && (c1_we || slot_free);
    end

`ifdef DDR_ARB_FIXED_PRIO_EN
    always_comb begin
        sel = !elig0;
    end
`else
    logic prio_q, prio_d;

    // prio_q names the port favoured on the next contended cycle.
    always_comb begin
        sel    = (elig0 && elig1) ? prio_q : !elig0;
        prio_d = cmd_fire ? !sel : prio_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    always_comb begin
        cmd_fire         = ddr_cmd_ready && (elig0 || elig1);
        sel_we           = sel ? c1_we : c0_we;
        ddr_cmd_en       = cmd_fire;
        ddr_wr_data_en   = cmd_fire && sel_we;
        ddr_cmd          = sel_we ? 3'b000 : 3'b001;
        ddr_addr         = sel ? c1_addr : c0_addr;
        ddr_wr_data      = sel ? c1_wdata : c0_wdata;
        ddr_wr_data_mask = sel ? c1_wmask : c0_wmask;
        c0_gnt           = cmd_fire && !sel;
        c1_gnt           = cmd_fire && sel;
    end

    // ---------------- Tag FIFO and read return ----------------
    always_comb begin
        push     = cmd_fire && !sel_we;
        pop      = ddr_rd_data_valid && (cnt_q != '0);
        spurious = ddr_rd_data_valid && (cnt_q == '0);
        head     = tag_q[rd_ptr_q];

        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (push) begin
            tag_d[wr_ptr_q] = sel;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        rvalid_d = {pop && head, pop && !head};
        rdata0_d = (pop && !head) ? ddr_rd_data : rdata0_q;
        rdata1_d = (pop && head) ? ddr_rd_data : rdata1_q;
        err_d    = err_q || spurious;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rvalid_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err_q    <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        c0_rvalid = rvalid_q[0];
        c1_rvalid = rvalid_q[1];
        c0_rdata  = rdata0_q;
        c1_rdata  = rdata1_q;
        busy      = (cnt_q != '0);
        err       = err_q;
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Self-checking bench for ddr_arbiter: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_ddr_arbiter;

    localparam int MaxOut = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req, we;
    logic [27:0]  addr  [2];
    logic [127:0] wdata [2];
    logic [15:0]  wmask [2];
    logic         gnt0, gnt1, rv0, rv1;
    logic [127:0] rd0, rd1;
    logic [2:0]   ddr_cmd;
    logic         ddr_cmd_en, ddr_wr_data_en;
    logic [27:0]  ddr_addr;
    logic [127:0] ddr_wr_data;
    logic [15:0]  ddr_wr_data_mask;
    logic         ddr_calib_done, ddr_cmd_ready, ddr_rd_data_valid;
    logic [127:0] ddr_rd_data;
    logic         busy, err;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit           m_cal;
    int           m_q[$];
    int           m_fav;
    bit           m_err;
    bit [1:0]     m_rv;
    logic [127:0] m_rd [2];
    bit           p_en, p_we;
    int           p_win;

    always #5 clk = ~clk;

    ddr_arbiter #(.MAX_OUT(MaxOut)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req(req[0]), .c0_we(we[0]), .c0_addr(addr[0]), .c0_wdata(wdata[0]),
        .c0_wmask(wmask[0]), .c0_gnt(gnt0), .c0_rvalid(rv0), .c0_rdata(rd0),
        .c1_req(req[1]), .c1_we(we[1]), .c1_addr(addr[1]), .c1_wdata(wdata[1]),
        .c1_wmask(wmask[1]), .c1_gnt(gnt1), .c1_rvalid(rv1), .c1_rdata(rd1),
        .ddr_cmd(ddr_cmd), .ddr_cmd_en(ddr_cmd_en), .ddr_addr(ddr_addr),
        .ddr_wr_data(ddr_wr_data), .ddr_wr_data_mask(ddr_wr_data_mask),
        .ddr_wr_data_en(ddr_wr_data_en), .ddr_calib_done(ddr_calib_done),
        .ddr_cmd_ready(ddr_cmd_ready), .ddr_rd_data(ddr_rd_data),
        .ddr_rd_data_valid(ddr_rd_data_valid), .busy(busy), .err(err)
    );

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic predict();
        bit e0, e1;
        e0 = rst_n && m_cal && req[0] && (we[0] || m_q.size() < MaxOut);
        e1 = rst_n && m_cal && req[1] && (we[1] || m_q.size() < MaxOut);
`ifdef DDR_ARB_FIXED_PRIO_EN
        p_win = e0 ? 0 : 1;
`else
        p_win = (e0 && e1) ? m_fav : (e0 ? 0 : 1);
`endif
        p_en = ddr_cmd_ready && (e0 || e1);
        p_we = we[p_win];
    endtask

    task automatic check_model();
        chk("cmd_en", ddr_cmd_en, p_en);
        chk("gnt0", gnt0, p_en && p_win == 0);
        chk("gnt1", gnt1, p_en && p_win == 1);
        chk("wr_data_en", ddr_wr_data_en, p_en && p_we);
        if (p_en) begin
            chk("cmd", ddr_cmd, p_we ? 3'b000 : 3'b001);
            chk("addr", ddr_addr, addr[p_win]);
            if (p_we) begin
                chk("wdata", ddr_wr_data, wdata[p_win]);
                chk("wmask", ddr_wr_data_mask, wmask[p_win]);
            end
        end
        chk("rvalid0", rv0, m_rv[0]);
        chk("rvalid1", rv1, m_rv[1]);
        if (m_rv[0]) chk("rdata0", rd0, m_rd[0]);
        if (m_rv[1]) chk("rdata1", rd1, m_rd[1]);
        chk("busy", busy, m_q.size() > 0);
        chk("err", err, m_err);
    endtask

    task automatic update();
        int t;
        if (!rst_n) begin
            m_cal = 0; m_q.delete(); m_fav = 0; m_err = 0; m_rv = '0;
        end else begin
            m_rv = '0;
            if (ddr_rd_data_valid) begin
                if (m_q.size() > 0) begin
                    t = m_q.pop_front();
                    m_rv[t] = 1'b1;
                    m_rd[t] = ddr_rd_data;
                end else begin
                    m_err = 1;
                end
            end
            if (p_en) begin
                m_fav = 1 - p_win;
                if (!p_we) m_q.push_back(p_win);
            end
            if (ddr_calib_done) m_cal = 1;
        end
    endtask

    task automatic settle();
        #1;
        predict();
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        update();
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; we = '0;
        ddr_cmd_ready = 1'b0; ddr_rd_data_valid = 1'b0; ddr_calib_done = 1'b0;
        ddr_rd_data = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = 28'(32'h100 * (i + 1)); wdata[i] = rand128(); wmask[i] = 16'h00FF;
        end
        @(posedge clk);
        update();
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic reset_cal();
        do_reset();
        ddr_calib_done = 1'b1;
        step();
    endtask

    typedef struct {
        bit r0, w0, r1, w1, rdy;
        bit en, wr;
        int g_rr, g_fp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen, n0, n1;
        int due[$];
        int wins[$];
        int g;

        tbl[0] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        tbl[2] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        tbl[3] = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
        tbl[4] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        tbl[5] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[6] = '{1, 0, 0, 0, 1, 1, 0, 0, 0};

        // Calibration gating
        do_reset();
        req = 2'b11; we = 2'b00; ddr_cmd_ready = 1'b1;
        seen = 0;
        repeat (100) begin
            settle();
            seen += int'(ddr_cmd_en) + int'(gnt0) + int'(gnt1);
            advance();
        end
        chk("cal_none", seen, 0);
        ddr_calib_done = 1'b1;
        settle(); chk("cal_edge", ddr_cmd_en, 0); advance();
        settle(); chk("cal_first", ddr_cmd_en, 1); advance();

        // Vector table
        reset_cal();
        for (int i = 0; i < 7; i++) begin
            req = {tbl[i].r1, tbl[i].r0}; we = {tbl[i].w1, tbl[i].w0};
            ddr_cmd_ready = tbl[i].rdy;
            addr[0] = 28'(32'h1000 + i); addr[1] = 28'(32'h2000 + i);
            settle();
`ifdef DDR_ARB_FIXED_PRIO_EN
            g = tbl[i].g_fp;
`else
            g = tbl[i].g_rr;
`endif
            chk("tbl_en", ddr_cmd_en, tbl[i].en);
            chk("tbl_wr_en", ddr_wr_data_en, tbl[i].wr);
            if (tbl[i].en) begin
                chk("tbl_gnt0", gnt0, g == 0);
                chk("tbl_gnt1", gnt1, g == 1);
                chk("tbl_cmd", ddr_cmd, tbl[i].wr ? 3'b000 : 3'b001);
            end
            advance();
        end

        // Contention: continuous reads on both ports, read latency 3
        reset_cal();
        we = 2'b00; ddr_cmd_ready = 1'b1;
        n0 = 0; n1 = 0;
        for (int c = 0; c < 32; c++) begin
            req = (c < 24) ? 2'b11 : 2'b00;
            ddr_rd_data_valid = (due.size() > 0 && due[0] == c);
            if (ddr_rd_data_valid) begin
                void'(due.pop_front());
                ddr_rd_data = rand128();
            end
            addr[0] = 28'($urandom); addr[1] = 28'($urandom);
            settle();
            if (gnt0 || gnt1) wins.push_back(gnt1 ? 1 : 0);
            n0 += int'(rv0);
            n1 += int'(rv1);
            if (p_en && !p_we) due.push_back(c + 3);
            advance();
        end
        ddr_rd_data_valid = 1'b0;
        chk("cont_ngrants", wins.size(), 24);
        for (int i = 0; i < wins.size(); i++) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
            chk("cont_fixed", wins[i], 0);
`else
            chk("cont_alt", wins[i], i % 2);
`endif
        end
`ifdef DDR_ARB_FIXED_PRIO_EN
        chk("cont_rv0", n0, 24);
        chk("cont_rv1", n1, 0);
`else
        chk("cont_rv0", n0, 12);
        chk("cont_rv1", n1, 12);
`endif

        // Backpressure: MAX_OUT reads outstanding, write on the other port still goes
        reset_cal();
        req = 2'b01; we = 2'b00; ddr_cmd_ready = 1'b1;
        repeat (MaxOut) step();
        settle(); chk("bp_busy", busy, 1); chk("bp_full", ddr_cmd_en, 0); advance();
        req = 2'b11; we = 2'b10;
        settle();
        chk("bp_gnt0", gnt0, 0); chk("bp_gnt1", gnt1, 1); chk("bp_cmd", ddr_cmd, 3'b000);
        advance();
        req = 2'b01;
        settle(); chk("bp_hold", ddr_cmd_en, 0); advance();
        req = 2'b00;
        for (int i = 0; i < MaxOut; i++) begin
            ddr_rd_data_valid = 1'b1; ddr_rd_data = rand128();
            step();
        end
        ddr_rd_data_valid = 1'b0;
        step(); step();

        // Port 1 write with full mask
        reset_cal();
        req = 2'b10; we = 2'b10; wmask[1] = 16'hFFFF; wdata[1] = rand128();
        ddr_cmd_ready = 1'b1;
        settle();
        chk("wr_cmd", ddr_cmd, 3'b000); chk("wr_en", ddr_wr_data_en, 1);
        chk("wr_gnt1", gnt1, 1); chk("wr_mask", ddr_wr_data_mask, 16'hFFFF);
        advance();
        req = 2'b00;
        settle(); chk("wr_busy", busy, 0); advance();

        // Spurious read data with empty FIFO
        reset_cal();
        ddr_rd_data_valid = 1'b1; ddr_rd_data = rand128();
        step();
        ddr_rd_data_valid = 1'b0;
        repeat (5) begin
            settle();
            chk("err_sticky", err, 1); chk("err_rv", rv0 | rv1, 0); chk("err_busy", busy, 0);
            advance();
        end
        reset_cal();
        settle(); chk("err_clr", err, 0); advance();

        // Reset with reads in flight: their data must not come back as rvalid
        req = 2'b11; we = 2'b00; ddr_cmd_ready = 1'b1;
        step(); step();
        settle(); chk("rst_busy_pre", busy, 1); advance();
        reset_cal();
        ddr_rd_data_valid = 1'b1; ddr_rd_data = rand128();
        step();
        settle(); chk("rst_norv_a", rv0 | rv1, 0); advance();
        ddr_rd_data_valid = 1'b0;
        settle(); chk("rst_norv_b", rv0 | rv1, 0); chk("rst_busy", busy, 0); advance();

        // Randomized traffic
        reset_cal();
        for (int c = 0; c < 600; c++) begin
            req = 2'($urandom); we = 2'($urandom);
            ddr_cmd_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                addr[i] = 28'($urandom); wdata[i] = rand128(); wmask[i] = 16'($urandom);
            end
            ddr_rd_data_valid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
            ddr_rd_data = rand128();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
